// File: rtl/mult_add_feeder.sv
// mult_add_feeder
//   Operand feeder for a 2-stage multiplier-adder (RES = A_reg2*B_reg2 + C).
//   Buffers (A,B,C) triplets in a small FIFO, issues A/B to the multiplier when
//   issue_en allows, and delays C plus a valid bit so they line up with RES.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active low
//   in_valid    input triplet valid
//   in_ready    FIFO can accept (registered !full)
//   in_a/b/c    multiplicand, multiplier, addend
//   issue_en    downstream permits an issue this cycle
//   mul_a/b     registered operands to the multiplier
//   mul_c       registered addend, aligned with RES
//   res_valid   RES at multiplier output is valid this cycle
//   fifo_count  entries held in the FIFO
//   issued_cnt  issues since reset, wraps modulo 2^CW
module mult_add_feeder #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_a,
    input  logic [DW-1:0]              in_b,
    input  logic [DW-1:0]              in_c,
    input  logic                       issue_en,
    output logic [DW-1:0]              mul_a,
    output logic [DW-1:0]              mul_b,
    output logic [DW-1:0]              mul_c,
    output logic                       res_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CW-1:0]              issued_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    logic [DW-1:0] mem_c [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Addend and valid travel two stages behind the issue edge so that they
    // meet RES after the multiplier's two internal register stages.
    logic [DW-1:0] c_s0, c_s1;
    logic          v_s0, v_s1;

    logic push;
    logic pop;
    logic [AW:0] count_next;

    // in_ready comes only from the registered count; a concurrent pop never
    // opens a slot in the same cycle.
    assign in_ready = (fifo_count != (AW+1)'(DEPTH));

    always_comb begin
        push       = in_valid & in_ready;
        pop        = issue_en & (fifo_count != '0);
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
                mem_c[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            c_s0       <= '0;
            v_s0       <= 1'b0;
            c_s1       <= '0;
            v_s1       <= 1'b0;
            mul_c      <= '0;
            res_valid  <= 1'b0;
            issued_cnt <= '0;
        end else begin
            if (push) begin
                mem_a[wr_ptr] <= in_a;
                mem_b[wr_ptr] <= in_b;
                mem_c[wr_ptr] <= in_c;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_next;

            // Bubbles issue zeros so idle slots carry no stale data.
            mul_a <= pop ? mem_a[rd_ptr] : '0;
            mul_b <= pop ? mem_b[rd_ptr] : '0;
            c_s0  <= pop ? mem_c[rd_ptr] : '0;
            v_s0  <= pop;

            c_s1      <= c_s0;
            v_s1      <= v_s0;
            mul_c     <= c_s1;
            res_valid <= v_s1;

            issued_cnt <= issued_cnt + CW'(pop);
        end
    end

endmodule

// File: tb/tb_mult_add_feeder.sv
// Bench for mult_add_feeder: directed scenarios plus random traffic, compared
// each cycle against a queue-based model of the FIFO and the issue history.
module tb_mult_add_feeder;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0, in_b = '0, in_c = '0;
    logic          issue_en = 1'b0;
    logic [DW-1:0] mul_a, mul_b, mul_c;
    logic          res_valid;
    logic [2:0]    fifo_count;
    logic [CW-1:0] issued_cnt;

    mult_add_feeder #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .issue_en   (issue_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c),
        .res_valid  (res_valid),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        bit [DW-1:0]   a;
        bit [DW-1:0]   b;
        bit [DW-1:0]   c;
    } trip_t;

    trip_t       fifo_q[$];
    trip_t       hist[$];      // what was issued at each of the last 3 edges
    int unsigned exp_issued;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned n_res = 0;

    // Downstream multiplier's operand registers, fed from the DUT outputs.
    bit [DW-1:0] a_r1, a_r2, b_r1, b_r2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        trip_t z;
        z = '{v: 1'b0, a: '0, b: '0, c: '0};
        fifo_q.delete();
        hist.delete();
        repeat (3) hist.push_back(z);
        exp_issued = 0;
    endtask

    task automatic cyc(input bit rst, input bit v, input bit [DW-1:0] a, input bit [DW-1:0] b,
                       input bit [DW-1:0] c, input bit ie);
        bit    do_push, do_pop;
        trip_t t, cur, old;
        @(negedge clk);
        rst_n    = ~rst;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        issue_en = ie;
        do_push  = v && (fifo_q.size() < DEPTH);
        do_pop   = ie && (fifo_q.size() != 0);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            t = '{v: 1'b0, a: '0, b: '0, c: '0};
            if (do_pop) begin
                t   = fifo_q.pop_front();
                t.v = 1'b1;
                exp_issued++;
            end
            hist.push_back(t);
            if (hist.size() > 3) void'(hist.pop_front());
            if (do_push) fifo_q.push_back('{v: 1'b1, a: a, b: b, c: c});
        end
        #1;
        cur = hist[2];
        old = hist[0];
        check_eq("in_ready",   32'(in_ready),   32'(fifo_q.size() < DEPTH));
        check_eq("fifo_count", 32'(fifo_count), fifo_q.size());
        check_eq("mul_a",      32'(mul_a),      32'(cur.a));
        check_eq("mul_b",      32'(mul_b),      32'(cur.b));
        check_eq("mul_c",      32'(mul_c),      32'(old.c));
        check_eq("res_valid",  32'(res_valid),  32'(old.v));
        check_eq("issued_cnt", 32'(issued_cnt), exp_issued % (1 << CW));
        if (old.v) begin
            n_res++;
            check_eq("res", 32'(a_r2) * 32'(b_r2) + 32'(mul_c),
                     32'(old.a) * 32'(old.b) + 32'(old.c));
        end
        a_r2 = a_r1;
        b_r2 = b_r1;
        a_r1 = mul_a;
        b_r1 = mul_b;
    endtask

    task automatic idle(input bit ie, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, ie);
    endtask

    initial begin
        model_clear();
        // Reset state
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        idle(1'b0, 1);

        // Single triplet, RES = 22
        cyc(1'b0, 1'b1, 8'd3, 8'd5, 8'd7, 1'b1);
        idle(1'b1, 4);

        // Burst of 4 with continuous issue
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 8'(10 + i), 8'(20 + i), 8'(30 + i), 1'b1);
        idle(1'b1, 4);

        // Fill to full with issue held off; 5th is held until a slot frees
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, 8'(40 + i), 8'(50 + i), 8'(60 + i), 1'b0);
        check_eq("full_count", 32'(fifo_count), 32'd4);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 1'b1, 8'd44, 8'd54, 8'd64, 1'b1);
        cyc(1'b0, 1'b1, 8'd44, 8'd54, 8'd64, 1'b1);
        idle(1'b1, 8);

        // Bubble: issue pattern 1,0,1
        cyc(1'b0, 1'b1, 8'd1, 8'd2, 8'd3, 1'b0);
        cyc(1'b0, 1'b1, 8'd4, 8'd5, 8'd6, 1'b1);
        cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
        cyc(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        idle(1'b0, 4);

        // Max values, RES = 65280
        cyc(1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 1'b0);
        idle(1'b1, 4);

        // Reset mid-flight: 2 in delay line, 2 in FIFO
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 8'(70 + i), 8'(80 + i), 8'(90 + i), 1'b0);
        idle(1'b1, 2);
        check_eq("pre_rst_cnt", 32'(fifo_count), 32'd2);
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_valid", 32'(res_valid), 32'd0);
        check_eq("rst_issued", 32'(issued_cnt), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        idle(1'b1, 3);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
        end
        idle(1'b1, 8);

        if (n_res < 100) check_eq("res_seen", n_res, 32'd100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
